alu_seq16: RTL and testbench
============================

Name: alu_seq16

Overview:
- Multi-cycle sequencer that drives the 8-bit ALU to perform 16-bit ADD, SUB, SHL-by-1 and CMP.
- Splits each 16-bit operation into a low-byte pass and a high-byte pass, carrying the ALU carry-out into the high pass, then aggregates 16-bit flags.
- Sits between the control/decode logic (start/cmd handshake) and the ALU; it is the ALU's only driver while busy.
- Uses only the ALU's kADD path (with carry-in) plus kCLR when idle. kSUB is never issued, because it ignores carry-in.

Parameters:
- W, 8, ALU datapath width; the operation width is 2*W (result width = 16 at default).

Ports:
- CLK  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled when not busy.
- cmd  in  2  operation: 00 ADD16, 01 SUB16, 10 SHL16 (shift left by 1), 11 CMP16.
- op_a  in  16  first operand (minuend for SUB/CMP; shift source for SHL).
- op_b  in  16  second operand (ignored for SHL).
- busy  out  1  high in LO and HI states.
- done  out  1  one-cycle pulse when a result and flags are valid.
- result  out  16  registered result.
- co  out  1  final carry; for SUB/CMP, 1 = no borrow.
- z  out  1  16-bit result == 0.
- neg  out  1  result bit 15.
- alu_op  out  4  ALU opcode (kADD or kCLR from the definitions package).
- alu_ci  out  1  ALU carry-in.
- alu_acc  out  8  ALU accumulator operand.
- alu_a  out  8  ALU second operand.
- alu_res  in  8  ALU result (combinational, same cycle).
- alu_co  in  1  ALU carry-out.

Behaviour:
- Reset: synchronous, active-high on CLK.
  - state=IDLE; busy=0, done=0, result=0, co=0, z=0, neg=0.
  - Internal operand, carry and low-byte registers are cleared.
  - Overrides any operation in flight; no done pulse is produced for an aborted operation.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - Drives alu_op=kCLR, alu_ci=0, alu_acc=0, alu_a=0.
  - On start=1: latch cmd, op_a, op_b; go to LO.
- LO:
  - Drives alu_op=kADD and alu_acc=A[7:0].
  - Operand B and carry-in by command:
    - ADD: alu_a=B[7:0], ci=0.
    - SUB/CMP: alu_a=~B[7:0], ci=1.
    - SHL: alu_a=A[7:0], ci=0.
  - At the clock edge: register alu_res into lo_byte and alu_co into carry; go to HI.
- HI:
  - Same as LO but uses byte [15:8], with ci=carry for all commands.
  - At the clock edge:
    - co <= alu_co.
    - neg <= alu_res[7].
    - z <= (alu_res==0) && (lo_byte==0).
    - result <= {alu_res, lo_byte}, except CMP, which leaves result unchanged.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0; ALU driven as in IDLE.
  - If start=1 in DONE, it is accepted exactly as in IDLE (next state LO); otherwise go to IDLE.
- Latency: start sampled at edge N -> done high during cycle N+3. Throughput is one op per 3 cycles.
- start while busy: ignored, with no queuing; latched operands are not disturbed.
- Input stability: cmd, op_a and op_b may change freely after the start edge.
- Output holding: result and flags hold their values until the next completed operation or reset.
- Arithmetic is modulo 2^16. Overflow (signed) is not reported.
- SHL16: co = original bit 15; bit 0 of the result = 0.

Test Plan:
- Reset, then ADD16 0x00FF + 0x0001 -> done at start+3 cycles; result=0x0100, co=0, z=0, neg=0; busy high for exactly 2 cycles.
- ADD16 0xFFFF + 0x0001 -> result=0x0000, co=1, z=1, neg=0. Also check that alu_ci=1 appears in the HI cycle.
- SUB16 0x1234 - 0x1235 -> result=0xFFFF, co=0, neg=1, z=0; then SUB16 0x1000 - 0x0001 -> result=0x0FFF, co=1.
- SHL16 0x8080 -> result=0x0100, co=1, z=0, neg=0. Then CMP16 0x5555 vs 0x5555 -> z=1, co=1, neg=0, result remains 0x0100.
- start held high continuously with changing operands: ops are accepted at IDLE/DONE edges only, done pulses every 3 cycles, and start pulses during busy are ignored without corrupting the in-flight result.
- reset asserted during HI of an ADD -> next cycle state IDLE, all outputs 0, no done pulse. A new ADD 0x0001 + 0x0001 afterwards -> result=0x0002.

Source files
------------

// File: rtl/alu_seq16.sv
// alu_seq16: multi-cycle sequencer that runs 16-bit ADD/SUB/SHL/CMP on an
// external 8-bit ALU as a low-byte pass followed by a carry-chained high pass.
//
// Ports:
//   CLK, reset            clock (rising edge), synchronous active-high reset
//   start, cmd            request pulse and opcode (00 ADD, 01 SUB, 10 SHL, 11 CMP)
//   op_a, op_b            16-bit operands (op_b ignored for SHL)
//   busy, done            busy in LO/HI; done pulses one cycle with the result
//   result, co, z, neg    registered 16-bit result and aggregated flags
//   alu_op/ci/acc/a       registered drive to the ALU (kADD while working, kCLR otherwise)
//   alu_res, alu_co       combinational ALU result and carry-out

package alu_seq16_pkg;

    // ALU opcodes used by the sequencer.
    localparam logic [3:0] kCLR = 4'h0;
    localparam logic [3:0] kADD = 4'h1;

    typedef enum logic [1:0] {
        CMD_ADD = 2'b00,
        CMD_SUB = 2'b01,
        CMD_SHL = 2'b10,
        CMD_CMP = 2'b11
    } cmd_e;

endpackage

module alu_seq16
    import alu_seq16_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     cmd,
    input  logic [2*W-1:0] op_a,
    input  logic [2*W-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           co,
    output logic           z,
    output logic           neg,
    output logic [3:0]     alu_op,
    output logic           alu_ci,
    output logic [W-1:0]   alu_acc,
    output logic [W-1:0]   alu_a,
    input  logic [W-1:0]   alu_res,
    input  logic           alu_co
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e         state_q;
    state_e         state_d;
    cmd_e           cmd_q;
    logic [W-1:0]   a_hi_q;
    logic [W-1:0]   b_hi_q;
    logic [W-1:0]   lo_q;

    logic           accept;
    logic [3:0]     alu_op_d;
    logic           alu_ci_d;
    logic [W-1:0]   alu_acc_d;
    logic [W-1:0]   alu_a_d;

    // Next state plus the ALU drive for the state being entered, so the
    // ALU-facing outputs come straight from flops. The low pass is fed from
    // the live inputs (they are only guaranteed at the start edge); the high
    // pass takes its carry-in directly from the low pass carry-out.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        alu_op_d  = kCLR;
        alu_ci_d  = 1'b0;
        alu_acc_d = '0;
        alu_a_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO:   state_d = S_HI;
            S_HI:   state_d = S_DONE;
            S_DONE: begin
                accept  = start;
                state_d = start ? S_LO : S_IDLE;
            end
        endcase

        if (accept) begin
            alu_op_d  = kADD;
            alu_acc_d = op_a[W-1:0];
            case (cmd_e'(cmd))
                CMD_ADD: alu_a_d = op_b[W-1:0];
                CMD_SUB,
                CMD_CMP: begin
                    alu_a_d  = ~op_b[W-1:0];
                    alu_ci_d = 1'b1;
                end
                CMD_SHL: alu_a_d = op_a[W-1:0];
            endcase
        end else if (state_q == S_LO) begin
            alu_op_d  = kADD;
            alu_acc_d = a_hi_q;
            alu_ci_d  = alu_co;
            case (cmd_q)
                CMD_ADD: alu_a_d = b_hi_q;
                CMD_SUB,
                CMD_CMP: alu_a_d = ~b_hi_q;
                CMD_SHL: alu_a_d = a_hi_q;
            endcase
        end
    end

    // State, operand latch, low-byte capture and result/flag registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_ADD;
            a_hi_q  <= '0;
            b_hi_q  <= '0;
            lo_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            co      <= 1'b0;
            z       <= 1'b0;
            neg     <= 1'b0;
            alu_op  <= kCLR;
            alu_ci  <= 1'b0;
            alu_acc <= '0;
            alu_a   <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == S_LO) || (state_d == S_HI);
            done    <= (state_d == S_DONE);
            alu_op  <= alu_op_d;
            alu_ci  <= alu_ci_d;
            alu_acc <= alu_acc_d;
            alu_a   <= alu_a_d;

            if (accept) begin
                cmd_q  <= cmd_e'(cmd);
                a_hi_q <= op_a[2*W-1:W];
                b_hi_q <= op_b[2*W-1:W];
            end

            if (state_q == S_LO) begin
                lo_q <= alu_res;
            end

            if (state_q == S_HI) begin
                co  <= alu_co;
                neg <= alu_res[W-1];
                z   <= (alu_res == '0) && (lo_q == '0);
                // CMP updates flags only.
                if (cmd_q != CMD_CMP) begin
                    result <= {alu_res, lo_q};
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Testbench for alu_seq16 with a behavioural 8-bit ALU and a result scoreboard.
module tb_alu_seq16;
    import alu_seq16_pkg::*;

    typedef struct packed {
        logic [15:0] result;
        logic        co;
        logic        z;
        logic        neg;
    } res_t;

    logic        CLK;
    logic        reset;
    logic        start;
    logic [1:0]  cmd;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        co;
    logic        z;
    logic        neg;
    logic [3:0]  alu_op;
    logic        alu_ci;
    logic [7:0]  alu_acc;
    logic [7:0]  alu_a;
    logic [7:0]  alu_res;
    logic        alu_co;
    logic [8:0]  alu_sum;

    int          checks;
    int          failures;
    int          cyc;
    logic [15:0] model_last;
    res_t        exp_q[$];
    res_t        obs_q[$];
    int          obs_cyc[$];

    alu_seq16 #(.W(8)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .cmd     (cmd),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .co      (co),
        .z       (z),
        .neg     (neg),
        .alu_op  (alu_op),
        .alu_ci  (alu_ci),
        .alu_acc (alu_acc),
        .alu_a   (alu_a),
        .alu_res (alu_res),
        .alu_co  (alu_co)
    );

    // Behavioural ALU: kADD adds with carry-in, anything else clears.
    always_comb begin
        alu_sum = 9'd0;
        if (alu_op == kADD) alu_sum = {1'b0, alu_acc} + {1'b0, alu_a} + 9'(alu_ci);
    end
    assign alu_res = alu_sum[7:0];
    assign alu_co  = alu_sum[8];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Completion monitor.
    always @(negedge CLK) begin
        if (done) begin
            obs_q.push_back({result, co, z, neg});
            obs_cyc.push_back(cyc);
        end
    end

    // Whole-word reference: co is the 17th bit, for SUB/CMP that means no borrow.
    function automatic res_t model(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] prev);
        logic [16:0] s;
        res_t        r;
        case (c)
            2'b00:   s = {1'b0, a} + {1'b0, b};
            2'b01,
            2'b11:   s = {1'b0, a} + {1'b0, ~b} + 17'd1;
            default: s = {a, 1'b0};
        endcase
        r.co     = s[16];
        r.z      = (s[15:0] == 16'd0);
        r.neg    = s[15];
        r.result = (c == 2'b11) ? prev : s[15:0];
        return r;
    endfunction

    task automatic push_exp(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
        res_t r;
        r = model(c, a, b, model_last);
        model_last = r.result;
        exp_q.push_back(r);
    endtask

    task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        start = 1'b1;
        cmd   = c;
        op_a  = a;
        op_b  = b;
    endtask

    task automatic scramble();
        start = 1'b0;
        cmd   = 2'($urandom_range(0, 3));
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
    endtask

    // Wait (bounded) for all expected completions, then pop and compare.
    task automatic drain(input string tag);
        int   waited;
        res_t e;
        res_t o;
        waited = 0;
        while (obs_q.size() < exp_q.size() && waited < 40) begin
            @(negedge CLK); #1;
            waited++;
        end
        if (obs_q.size() < exp_q.size()) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got %0d results, required %0d", tag, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s_result: got res=%h co=%b z=%b neg=%b, required res=%h co=%b z=%b neg=%b",
                         tag, o.result, o.co, o.z, o.neg, e.result, e.co, e.z, e.neg);
            end
        end
        if (obs_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL %s_extra_done: got %0d unexpected results, required 0", tag, obs_q.size());
        end
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({busy, done, result, co, z, neg} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h co=%b z=%b neg=%b, required all 0",
                     busy, done, result, co, z, neg);
        end
        checks++;
        if (alu_op !== kCLR || alu_ci !== 1'b0 || alu_acc !== 8'd0 || alu_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_alu_drive: got op=%h ci=%b acc=%h a=%h, required op=%h ci=0 acc=00 a=00",
                     alu_op, alu_ci, alu_acc, alu_a, kCLR);
        end
        reset = 1'b0;
        model_last = 16'd0;
        @(negedge CLK);
    endtask

    task automatic test_add_basic();
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = 0;
        issue(2'b00, 16'h00FF, 16'h0001);
        push_exp(2'b00, 16'h00FF, 16'h0001);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = k;
            if (k == 1) begin
                checks++;
                if (alu_op !== kADD || alu_acc !== 8'hFF || alu_a !== 8'h01 || alu_ci !== 1'b0) begin
                    failures++;
                    $display("FAIL add_lo_drive: got op=%h acc=%h a=%h ci=%b, required op=%h acc=ff a=01 ci=0",
                             alu_op, alu_acc, alu_a, alu_ci, kADD);
                end
                scramble();
            end
        end
        checks++;
        if (busy_cnt != 2) begin
            failures++;
            $display("FAIL add_busy_cycles: got %0d, required 2", busy_cnt);
        end
        checks++;
        if (done_at != 3) begin
            failures++;
            $display("FAIL add_latency: done seen at cycle %0d after start, required 3", done_at);
        end
        drain("add_basic");
    endtask

    task automatic test_add_carry();
        issue(2'b00, 16'hFFFF, 16'h0001);
        push_exp(2'b00, 16'hFFFF, 16'h0001);
        @(negedge CLK);
        scramble();
        @(negedge CLK);
        checks++;
        if (alu_ci !== 1'b1 || alu_op !== kADD || alu_acc !== 8'hFF || alu_a !== 8'h00) begin
            failures++;
            $display("FAIL add_hi_carry_in: got op=%h ci=%b acc=%h a=%h, required op=%h ci=1 acc=ff a=00",
                     alu_op, alu_ci, alu_acc, alu_a, kADD);
        end
        drain("add_carry");
    endtask

    task automatic test_sub();
        issue(2'b01, 16'h1234, 16'h1235);
        push_exp(2'b01, 16'h1234, 16'h1235);
        @(negedge CLK);
        scramble();
        drain("sub_borrow");
        issue(2'b01, 16'h1000, 16'h0001);
        push_exp(2'b01, 16'h1000, 16'h0001);
        @(negedge CLK);
        scramble();
        drain("sub_no_borrow");
    endtask

    task automatic test_shl_cmp();
        issue(2'b10, 16'h8080, 16'hABCD);
        push_exp(2'b10, 16'h8080, 16'hABCD);
        @(negedge CLK);
        scramble();
        drain("shl");
        issue(2'b11, 16'h5555, 16'h5555);
        push_exp(2'b11, 16'h5555, 16'h5555);
        @(negedge CLK);
        scramble();
        drain("cmp_equal");
    endtask

    // start held high: only every third edge (IDLE or DONE) accepts.
    task automatic test_back_to_back();
        int n_done;
        int bad_gap;
        @(negedge CLK);
        for (int j = 0; j < 12; j++) begin
            start = 1'b1;
            cmd   = 2'($urandom_range(0, 3));
            op_a  = 16'($urandom);
            op_b  = 16'($urandom);
            if (j == 1) begin
                cmd  = 2'b00;
                op_a = 16'hFFFF;
                op_b = 16'hFFFF;
            end
            if (j % 3 == 0) push_exp(cmd, op_a, op_b);
            @(negedge CLK);
        end
        start = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        n_done  = obs_cyc.size();
        bad_gap = 0;
        for (int i = 1; i < obs_cyc.size(); i++) begin
            if (obs_cyc[i] - obs_cyc[i-1] != 3) bad_gap++;
        end
        checks++;
        if (n_done != 4) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d, required 4", n_done);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL b2b_done_spacing: got %0d gaps not equal to 3, required 0", bad_gap);
        end
        drain("b2b");
    endtask

    task automatic test_reset_midop();
        issue(2'b00, 16'h1234, 16'h1111);
        @(negedge CLK);
        scramble();
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midop_in_hi: got busy=%b, required 1", busy);
        end
        reset = 1'b1;
        @(negedge CLK);
        checks++;
        if ({busy, done, result, co, z, neg} !== 21'd0 || alu_op !== kCLR) begin
            failures++;
            $display("FAIL midop_reset_outputs: got busy=%b done=%b res=%h co=%b z=%b neg=%b op=%h, required all 0 op=%h",
                     busy, done, result, co, z, neg, alu_op, kCLR);
        end
        reset = 1'b0;
        model_last = 16'd0;
        repeat (4) @(negedge CLK);
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midop_no_done: got %0d done pulses, required 0", obs_q.size());
        end
        obs_q.delete();
        obs_cyc.delete();
        issue(2'b00, 16'h0001, 16'h0001);
        push_exp(2'b00, 16'h0001, 16'h0001);
        @(negedge CLK);
        scramble();
        drain("after_reset_add");
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        model_last = 16'd0;
        reset      = 1'b1;
        start      = 1'b0;
        cmd        = 2'b00;
        op_a       = 16'd0;
        op_b       = 16'd0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_shl_cmp();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
